// File: rtl/lpc_io_cycle_if.sv
// LPC target-side bus bundle: LAD/LFRAME# wire side plus the register-file port.
interface lpc_io_cycle_if;
  logic       LFRAME_n;
  logic [3:0] LAD_in;
  logic [3:0] LAD_out;
  logic       LAD_oe;
  logic [7:0] Addr;
  logic       Wr;
  logic [7:0] DataWr;
  logic [7:0] RdData;

  modport slave (
    input  LFRAME_n, LAD_in, RdData,
    output LAD_out, LAD_oe, Addr, Wr, DataWr
  );

  modport master (
    output LFRAME_n, LAD_in, RdData,
    input  LAD_out, LAD_oe, Addr, Wr, DataWr
  );
endinterface

// File: rtl/lpc_io_cycle.sv
// LPC I/O read/write target claiming a 32-byte window at BASE_ADDR.
// Define LPC_SYNC_WAIT_EN to insert one short-wait SYNC nibble before ready.
module lpc_io_cycle #(
  parameter logic [15:0] BASE_ADDR = 16'h0800
) (
  input  logic          LpcClock,
  input  logic          PciReset,
  lpc_io_cycle_if.slave lpc
);

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IO_W   = 16;

`ifdef LPC_SYNC_WAIT_EN
  localparam logic [1:0] SYNC_LAST = 2'd1;
`else
  localparam logic [1:0] SYNC_LAST = 2'd0;
`endif

  typedef enum logic [2:0] {
    IDLE, CYCTYPE, ADDR, WDATA, HTAR, SYNC, RDATA, PTAR
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [IO_W-5:0]     ioaddr_q, ioaddr_d;
  logic                dir_wr_q, dir_wr_d;
  logic [BYTE_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   data_wr_q, data_wr_d;
  logic [BYTE_W-1:0]   rdata_q, rdata_d;
  logic                lad_oe_q, lad_oe_d;
  logic [NIB_W-1:0]    lad_out_q, lad_out_d;
  logic                wr_q, wr_d;
  logic [IO_W-1:0]     io_full;
  logic                addr_match;

  // Next-state, datapath and next-output decode; outputs are registered from the next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ioaddr_d   = ioaddr_q;
    dir_wr_d   = dir_wr_q;
    addr_d     = addr_q;
    data_wr_d  = data_wr_q;
    rdata_d    = rdata_q;
    io_full    = {ioaddr_q, lpc.LAD_in};
    addr_match = (io_full[15:5] == BASE_ADDR[15:5]);

    if (!lpc.LFRAME_n) begin
      state_d = (lpc.LAD_in == 4'h0) ? CYCTYPE : IDLE;
      cnt_d   = 2'd0;
    end else begin
      unique case (state_q)
        IDLE: ;
        CYCTYPE: begin
          cnt_d = 2'd0;
          if (lpc.LAD_in == 4'h0) begin
            dir_wr_d = 1'b0;
            state_d  = ADDR;
          end else if (lpc.LAD_in == 4'h2) begin
            dir_wr_d = 1'b1;
            state_d  = ADDR;
          end else begin
            state_d  = IDLE;
          end
        end
        ADDR: begin
          ioaddr_d = io_full[IO_W-5:0];
          cnt_d    = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cnt_d = 2'd0;
            if (addr_match) begin
              addr_d  = {3'b000, io_full[4:0]};
              state_d = dir_wr_q ? WDATA : HTAR;
            end else begin
              state_d = IDLE;
            end
          end
        end
        WDATA: begin
          if (cnt_q == 2'd0) begin
            data_wr_d[3:0] = lpc.LAD_in;
            cnt_d          = 2'd1;
          end else begin
            data_wr_d[7:4] = lpc.LAD_in;
            cnt_d          = 2'd0;
            state_d        = HTAR;
          end
        end
        HTAR: begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd1) begin
            cnt_d   = 2'd0;
            state_d = SYNC;
          end
        end
        SYNC: begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == SYNC_LAST) begin
            cnt_d = 2'd0;
            if (!dir_wr_q) rdata_d = lpc.RdData;
            state_d = dir_wr_q ? PTAR : RDATA;
          end
        end
        RDATA: begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd1) begin
            cnt_d   = 2'd0;
            state_d = PTAR;
          end
        end
        PTAR: begin
          cnt_d   = 2'd0;
          state_d = IDLE;
        end
        default: begin
          cnt_d   = 2'd0;
          state_d = IDLE;
        end
      endcase
    end

    lad_oe_d  = (state_d == SYNC) || (state_d == RDATA) || (state_d == PTAR);
    lad_out_d = 4'hF;
    wr_d      = 1'b0;
    case (state_d)
      SYNC: begin
        lad_out_d = (cnt_d == SYNC_LAST) ? 4'h0 : 4'h5;
        wr_d      = dir_wr_q && (cnt_d == SYNC_LAST);
      end
      // Low nibble comes straight from the register file on the latching edge
      RDATA:   lad_out_d = (cnt_d == 2'd0) ? lpc.RdData[3:0] : rdata_q[7:4];
      default: lad_out_d = 4'hF;
    endcase
  end

  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      ioaddr_q  <= '0;
      dir_wr_q  <= 1'b0;
      addr_q    <= 8'h00;
      data_wr_q <= 8'h00;
      rdata_q   <= 8'h00;
      lad_oe_q  <= 1'b0;
      lad_out_q <= 4'hF;
      wr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ioaddr_q  <= ioaddr_d;
      dir_wr_q  <= dir_wr_d;
      addr_q    <= addr_d;
      data_wr_q <= data_wr_d;
      rdata_q   <= rdata_d;
      lad_oe_q  <= lad_oe_d;
      lad_out_q <= lad_out_d;
      wr_q      <= wr_d;
    end
  end

  assign lpc.LAD_oe  = lad_oe_q;
  assign lpc.LAD_out = lad_out_q;
  assign lpc.Addr    = addr_q;
  assign lpc.Wr      = wr_q;
  assign lpc.DataWr  = data_wr_q;

endmodule

// File: tb/tb_lpc_io_cycle.sv
// Directed bench for lpc_io_cycle: claimed write/read, unclaimed, abort, mid-cycle reset.
module tb_lpc_io_cycle;

  logic LpcClock = 1'b0;
  logic PciReset;
  int   checks   = 0;
  int   failures = 0;

  lpc_io_cycle_if bus();

  lpc_io_cycle #(.BASE_ADDR(16'h0800)) dut (
    .LpcClock (LpcClock),
    .PciReset (PciReset),
    .lpc      (bus)
  );

  always #15 LpcClock = ~LpcClock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one LPC clock's worth of host signals; returns mid-clock where outputs are sampled
  task automatic cyc(input logic lf, input logic [3:0] lad);
    @(negedge LpcClock);
    bus.LFRAME_n = lf;
    bus.LAD_in   = lad;
  endtask

  task automatic hdr_body(input logic [3:0] ctype, input logic [15:0] a);
    cyc(1'b1, ctype);
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'(a >> (12 - 4 * i)));
  endtask

  task automatic send_hdr(input logic [3:0] ctype, input logic [15:0] a);
    cyc(1'b0, 4'h0);
    hdr_body(ctype, a);
  endtask

  task automatic send_data(input logic [7:0] d);
    cyc(1'b1, d[3:0]);
    chk("addr_after_hdr_oe", 8'(bus.LAD_oe), 8'h0);
    cyc(1'b1, d[7:4]);
  endtask

  // Host turnaround, SYNC, PTAR and release for a claimed write
  task automatic write_tail(input logic [7:0] a, input logic [7:0] d);
    cyc(1'b1, 4'hF);
    chk("w_htar0_oe", 8'(bus.LAD_oe), 8'h0);
    chk("w_htar0_wr", 8'(bus.Wr), 8'h0);
    cyc(1'b1, 4'hF);
    chk("w_htar1_oe", 8'(bus.LAD_oe), 8'h0);
`ifdef LPC_SYNC_WAIT_EN
    cyc(1'b1, 4'hF);
    chk("w_wait_oe", 8'(bus.LAD_oe), 8'h1);
    chk("w_wait_lad", 8'(bus.LAD_out), 8'h5);
    chk("w_wait_wr", 8'(bus.Wr), 8'h0);
`endif
    cyc(1'b1, 4'hF);
    chk("w_sync_oe", 8'(bus.LAD_oe), 8'h1);
    chk("w_sync_lad", 8'(bus.LAD_out), 8'h0);
    chk("w_sync_wr", 8'(bus.Wr), 8'h1);
    chk("w_sync_addr", bus.Addr, a);
    chk("w_sync_data", bus.DataWr, d);
    cyc(1'b1, 4'hF);
    chk("w_ptar_oe", 8'(bus.LAD_oe), 8'h1);
    chk("w_ptar_lad", 8'(bus.LAD_out), 8'hF);
    chk("w_ptar_wr", 8'(bus.Wr), 8'h0);
    cyc(1'b1, 4'hF);
    chk("w_rel_oe", 8'(bus.LAD_oe), 8'h0);
    chk("w_rel_lad", 8'(bus.LAD_out), 8'hF);
  endtask

  initial begin
    PciReset     = 1'b1;
    bus.LFRAME_n = 1'b1;
    bus.LAD_in   = 4'hF;
    bus.RdData   = 8'h00;
    repeat (3) @(negedge LpcClock);
    chk("rst_oe", 8'(bus.LAD_oe), 8'h0);
    chk("rst_lad", 8'(bus.LAD_out), 8'hF);
    chk("rst_wr", 8'(bus.Wr), 8'h0);
    chk("rst_addr", bus.Addr, 8'h00);
    chk("rst_data", bus.DataWr, 8'h00);
    PciReset = 1'b0;
    cyc(1'b1, 4'hF);

    // Claimed write 0x0804 <- 0xA5
    send_hdr(4'h2, 16'h0804);
    send_data(8'hA5);
    chk("w1_addr_loaded", bus.Addr, 8'h04);
    write_tail(8'h04, 8'hA5);

    // Claimed read 0x081F, RdData 0x5A latched at end of SYNC
    bus.RdData = 8'h5A;
    send_hdr(4'h0, 16'h081F);
    cyc(1'b1, 4'hF);
    chk("r_htar0_oe", 8'(bus.LAD_oe), 8'h0);
    chk("r_addr", bus.Addr, 8'h1F);
    cyc(1'b1, 4'hF);
    chk("r_htar1_oe", 8'(bus.LAD_oe), 8'h0);
`ifdef LPC_SYNC_WAIT_EN
    cyc(1'b1, 4'hF);
    chk("r_wait_lad", 8'(bus.LAD_out), 8'h5);
`endif
    cyc(1'b1, 4'hF);
    chk("r_sync_oe", 8'(bus.LAD_oe), 8'h1);
    chk("r_sync_lad", 8'(bus.LAD_out), 8'h0);
    chk("r_sync_wr", 8'(bus.Wr), 8'h0);
    cyc(1'b1, 4'hF);
    bus.RdData = 8'h00;
    chk("r_lo_lad", 8'(bus.LAD_out), 8'hA);
    chk("r_lo_wr", 8'(bus.Wr), 8'h0);
    cyc(1'b1, 4'hF);
    chk("r_hi_lad", 8'(bus.LAD_out), 8'h5);
    chk("r_hi_oe", 8'(bus.LAD_oe), 8'h1);
    cyc(1'b1, 4'hF);
    chk("r_ptar_lad", 8'(bus.LAD_out), 8'hF);
    chk("r_ptar_oe", 8'(bus.LAD_oe), 8'h1);
    cyc(1'b1, 4'hF);
    chk("r_rel_oe", 8'(bus.LAD_oe), 8'h0);

    // Unclaimed write 0x0904: nothing driven, Addr holds previous claim
    send_hdr(4'h2, 16'h0904);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 4'h3);
      chk("unclaimed_oe", 8'(bus.LAD_oe), 8'h0);
      chk("unclaimed_wr", 8'(bus.Wr), 8'h0);
    end
    chk("unclaimed_addr_hold", bus.Addr, 8'h1F);

    // Following valid write is claimed
    send_hdr(4'h2, 16'h0810);
    send_data(8'h3C);
    write_tail(8'h10, 8'h3C);

    // START during WDATA restarts decode; aborted frame gives no Wr
    send_hdr(4'h2, 16'h0808);
    cyc(1'b1, 4'h7);
    cyc(1'b0, 4'h0);
    chk("abort_wr", 8'(bus.Wr), 8'h0);
    hdr_body(4'h2, 16'h080C);
    chk("abort_oe", 8'(bus.LAD_oe), 8'h0);
    send_data(8'hE1);
    chk("abort_addr", bus.Addr, 8'h0C);
    write_tail(8'h0C, 8'hE1);

    // Reset during read HTAR releases LAD and clears Addr
    bus.RdData = 8'h77;
    send_hdr(4'h0, 16'h0801);
    cyc(1'b1, 4'hF);
    chk("rstmid_addr_pre", bus.Addr, 8'h01);
    PciReset = 1'b1;
    cyc(1'b1, 4'hF);
    PciReset = 1'b0;
    chk("rstmid_oe", 8'(bus.LAD_oe), 8'h0);
    chk("rstmid_addr", bus.Addr, 8'h00);
    chk("rstmid_lad", 8'(bus.LAD_out), 8'hF);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 4'hF);
      chk("rstmid_no_sync", 8'(bus.LAD_oe), 8'h0);
      chk("rstmid_no_wr", 8'(bus.Wr), 8'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
